tdm_demux_dual4: RTL and testbench
==================================

// Module: tdm_demux_dual4
// PURPOSE
//  Dual 1-to-4 time-division demultiplexer: the receive end of the dual 4:1 selector path.
//  A 2-bit slot sequencer, synchronised by a frame marker, steers each serial group input
//  into one of four lane registers. The block presents each group's four lanes in parallel.
//  Sits on the datapath side wherever a 4-slot TDM stream built by the selectors is unpacked.
// PARAMETERS
//  WIDTH   1   bits per slot per group
// PORTS
//  clk          in   1        system clock; all state changes on rising edge
//  reset        in   1        synchronous, active-high
//  frame_n      in   1        active-low frame marker; low = current sample is slot 0
//  enb1_n       in   1        active-low capture enable, group 1
//  enb2_n       in   1        active-low capture enable, group 2
//  g1d          in   WIDTH    serial data, group 1
//  g2d          in   WIDTH    serial data, group 2
//  g1q          out  4*WIDTH  group 1 lanes; lane k at [k*WIDTH +: WIDTH]
//  g2q          out  4*WIDTH  group 2 lanes, same packing
//  slot         out  2        slot index the next sample will be written to
//  locked       out  1        sequencer in LOCKED state
//  frame_done   out  1        1-cycle pulse: slot 3 was sampled on the previous edge
//  sync_err     out  1        1-cycle pulse: frame_n arrived while slot != 0
// BEHAVIOUR
//  - Reset: state=HUNT, slot=0, all lane regs, g1q, g2q=0, locked/frame_done/sync_err=0.
//    Reset wins over every other input on the same edge, including mid-frame.
//  - HUNT: slot is held at 0 and nothing is captured. If frame_n=0, the edge samples slot 0,
//    goes to LOCKED, and sets slot to 1.
//  - LOCKED: on every edge the effective slot s is 0 if frame_n=0, else slot. The edge writes
//    lane s and sets slot to (s+1) mod 4. After slot 3, slot wraps to 0 without needing a marker.
//  - Capture is per group: lane[s] of group g loads gXd only when enbX_n=0; otherwise the lane
//    holds. Groups are independent; both may capture on the same edge.
//  - frame_n=0 while LOCKED and slot!=0: sync_err pulses the next cycle; this edge samples slot 0
//    (resync); the state stays LOCKED. frame_n=0 with slot==0 is a normal marker, no error.
//  - frame_done is registered. It is 1 in the cycle after an edge that sampled s=3, regardless
//    of enables. A marker on that same edge (s forced 0) means no frame_done.
//  - Latency: data is sampled at edge N and is visible on gXq after edge N (undbuffered)
//    or with frame_done (buffered).
//  - locked=1 exactly when state==LOCKED; it returns to 0 only on reset.
// CONFIGURATION
//  TDM_DEMUX_DBUF_EN defined: each group gets a second 4*WIDTH output register. It loads
//   atomically from the lane regs (including the slot-3 sample) in the same cycle frame_done=1.
//   gXq are frame-coherent and otherwise hold.
//  TDM_DEMUX_DBUF_EN undefined: gXq are the lane regs themselves, updating one slot per edge.
// STRUCTURE
//  - Package tdm_demux_pkg: state enum {HUNT, LOCKED}; localparam NSLOTS=4, SLOT_W=2.
//  - Sub-module tdm_slot_lane (params WIDTH): one group's 4 lane regs, write decode, and the
//    optional output buffer. It is instantiated twice; the sequencer/FSM stays at the top level.
// TESTING
//  1. Reset, then frame_n=0 with g1d=1,0,1,1 over 4 cycles, enb1_n=0 -> g1q=4'b1101,
//     frame_done pulses once, locked=1.
//  2. No marker after reset: 10 clocks of data -> slot=0, g1q=g2q=0, frame_done never asserts.
//  3. Marker injected at slot 2 -> sync_err pulses 1 cycle; that sample lands in lane 0;
//     slot=1 next cycle.
//  4. enb2_n=1 during slot 1 only, g2d=1 all slots -> g2q=4'b1101; g1 unaffected.
//  5. reset asserted mid-frame (slot 2) -> next cycle all outputs 0, locked=0, state HUNT.
//  6. WIDTH=4 with DBUF_EN on and off: lanes A,B,C,D -> g1q=16'hDCBA; buffered run shows 0
//     until frame_done, unbuffered run shows the lanes filling one per cycle.

Source files
------------

// File: rtl/tdm_demux_pkg.sv
// Shared types and constants for the dual 4-slot TDM demultiplexer.
// Optional output double-buffering is selected by TDM_DEMUX_DBUF_EN.
package tdm_demux_pkg;

    localparam int NSLOTS = 4;
    localparam int SLOT_W = 2;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/tdm_demux_dual4_if.sv
// Bus bundle for tdm_demux_dual4: serial inputs, enables, marker and the parallel/status outputs.
// Output coherence depends on TDM_DEMUX_DBUF_EN in the design that drives it.
interface tdm_demux_dual4_if #(
    parameter int WIDTH = 1
);
    logic               frame_n;
    logic               enb1_n;
    logic               enb2_n;
    logic [WIDTH-1:0]   g1d;
    logic [WIDTH-1:0]   g2d;
    logic [4*WIDTH-1:0] g1q;
    logic [4*WIDTH-1:0] g2q;
    logic [1:0]         slot;
    logic               locked;
    logic               frame_done;
    logic               sync_err;

    modport master (
        output frame_n, enb1_n, enb2_n, g1d, g2d,
        input  g1q, g2q, slot, locked, frame_done, sync_err
    );

    modport slave (
        input  frame_n, enb1_n, enb2_n, g1d, g2d,
        output g1q, g2q, slot, locked, frame_done, sync_err
    );
endinterface

// File: rtl/tdm_slot_lane.sv
// One group's four lane registers with slot write decode and optional frame output buffer.
// TDM_DEMUX_DBUF_EN defined: q is a frame-coherent copy; otherwise q is the lane regs.
module tdm_slot_lane
    import tdm_demux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic                    capture_n,
    input  logic [SLOT_W-1:0]       wr_slot,
    input  logic [WIDTH-1:0]        d,
    input  logic                    frame_end,
    output logic [NSLOTS*WIDTH-1:0] q
);

    logic [NSLOTS-1:0][WIDTH-1:0] lane_reg;
    logic [NSLOTS-1:0][WIDTH-1:0] lane_next;

    generate
        for (genvar gi = 0; gi < NSLOTS; gi++) begin : g_lane
            assign lane_next[gi] = (wr_en && !capture_n && (wr_slot == SLOT_W'(gi)))
                                   ? d : lane_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            lane_reg <= '0;
        end else begin
            lane_reg <= lane_next;
        end
    end

`ifdef TDM_DEMUX_DBUF_EN
    logic [NSLOTS-1:0][WIDTH-1:0] buf_reg;

    // Load from lane_next so the slot-3 sample taken on this same edge is included.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_reg <= '0;
        end else if (frame_end) begin
            buf_reg <= lane_next;
        end
    end

    assign q = buf_reg;
`else
    logic unused_frame_end;
    assign unused_frame_end = frame_end;
    assign q = lane_reg;
`endif

endmodule

// File: rtl/tdm_demux_dual4.sv
// Dual 1-to-4 TDM demultiplexer: marker-synchronised slot sequencer steering two serial groups.
// Define TDM_DEMUX_DBUF_EN for frame-coherent (double-buffered) lane outputs.
module tdm_demux_dual4
    import tdm_demux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic               clk,
    input  logic               reset,
    tdm_demux_dual4_if.slave   bus
);

    state_t              state_reg, state_next;
    logic [SLOT_W-1:0]   slot_reg, slot_next;
    logic                frame_done_reg, frame_done_next;
    logic                sync_err_reg, sync_err_next;
    logic [SLOT_W-1:0]   eff_slot;
    logic                wr_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= HUNT;
            slot_reg       <= '0;
            frame_done_reg <= 1'b0;
            sync_err_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            slot_reg       <= slot_next;
            frame_done_reg <= frame_done_next;
            sync_err_reg   <= sync_err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        slot_next       = slot_reg;
        frame_done_next = 1'b0;
        sync_err_next   = 1'b0;
        eff_slot        = bus.frame_n ? slot_reg : '0;
        wr_en           = 1'b0;
        case (state_reg)
            HUNT: begin
                slot_next = '0;
                if (!bus.frame_n) begin
                    wr_en      = 1'b1;
                    state_next = LOCKED;
                    slot_next  = eff_slot + 1'b1;
                end
            end
            LOCKED: begin
                wr_en           = 1'b1;
                slot_next       = eff_slot + 1'b1;
                frame_done_next = (eff_slot == SLOT_W'(NSLOTS - 1));
                // A marker anywhere but slot 0 is a resync, flagged but not fatal.
                sync_err_next   = !bus.frame_n && (slot_reg != '0);
            end
            default: begin
                state_next = HUNT;
                slot_next  = '0;
            end
        endcase
    end

    tdm_slot_lane #(.WIDTH(WIDTH)) u_lane_g1 (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .capture_n (bus.enb1_n),
        .wr_slot   (eff_slot),
        .d         (bus.g1d),
        .frame_end (frame_done_next),
        .q         (bus.g1q)
    );

    tdm_slot_lane #(.WIDTH(WIDTH)) u_lane_g2 (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .capture_n (bus.enb2_n),
        .wr_slot   (eff_slot),
        .d         (bus.g2d),
        .frame_end (frame_done_next),
        .q         (bus.g2q)
    );

    assign bus.slot       = slot_reg;
    assign bus.locked     = (state_reg == LOCKED);
    assign bus.frame_done = frame_done_reg;
    assign bus.sync_err   = sync_err_reg;

endmodule

// File: tb/tb_tdm_demux_dual4.sv
// Directed bench for tdm_demux_dual4: a WIDTH=1 and a WIDTH=4 instance sharing clock and reset.
// Expectations follow TDM_DEMUX_DBUF_EN when the bench is compiled with it.
module tb_tdm_demux_dual4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    tdm_demux_dual4_if #(.WIDTH(1)) bus1 ();
    tdm_demux_dual4_if #(.WIDTH(4)) bus4 ();

    tdm_demux_dual4 #(.WIDTH(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
    tdm_demux_dual4 #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));

`ifdef TDM_DEMUX_DBUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-18s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic fr, input logic e1, input logic e2,
                          input logic d1, input logic d2);
        bus1.frame_n = fr;
        bus1.enb1_n  = e1;
        bus1.enb2_n  = e2;
        bus1.g1d     = d1;
        bus1.g2d     = d2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    logic [3:0]  exp4;
    logic [15:0] exp16;
    logic [3:0]  nib [4];

    initial begin
        drive1(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        bus4.frame_n = 1'b1; bus4.enb1_n = 1'b1; bus4.enb2_n = 1'b1;
        bus4.g1d = 4'h0; bus4.g2d = 4'h0;

        // Reset state
        do_reset();
        chk("rst_slot", 32'(bus1.slot), 32'd0);
        chk("rst_locked", 32'(bus1.locked), 32'd0);
        chk("rst_g1q", 32'(bus1.g1q), 32'd0);
        chk("rst_fdone", 32'(bus1.frame_done), 32'd0);

        // Test 1: marker then g1d = 1,0,1,1
        drive1(1'b0, 1'b0, 1'b1, 1'b1, 1'b1); step();
        chk("t1_locked", 32'(bus1.locked), 32'd1);
        chk("t1_slot1", 32'(bus1.slot), 32'd1);
        chk("t1_g1q_s0", 32'(bus1.g1q), DBUF ? 32'h0 : 32'h1);
        drive1(1'b1, 1'b0, 1'b1, 1'b0, 1'b1); step();
        drive1(1'b1, 1'b0, 1'b1, 1'b1, 1'b1); step();
        chk("t1_fdone_early", 32'(bus1.frame_done), 32'd0);
        drive1(1'b1, 1'b0, 1'b1, 1'b1, 1'b1); step();
        chk("t1_fdone", 32'(bus1.frame_done), 32'd1);
        chk("t1_g1q", 32'(bus1.g1q), 32'hD);
        chk("t1_g2q", 32'(bus1.g2q), 32'h0);
        chk("t1_wrap", 32'(bus1.slot), 32'd0);
        drive1(1'b1, 1'b1, 1'b1, 1'b0, 1'b0); step();
        chk("t1_fdone_once", 32'(bus1.frame_done), 32'd0);
        chk("t1_slot_after", 32'(bus1.slot), 32'd1);
        step();
        chk("t3_slot2", 32'(bus1.slot), 32'd2);

        // Test 3: marker at slot 2 with g1d=0 lands in lane 0
        drive1(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); step();
        chk("t3_sync_err", 32'(bus1.sync_err), 32'd1);
        chk("t3_slot", 32'(bus1.slot), 32'd1);
        chk("t3_g1q", 32'(bus1.g1q), DBUF ? 32'hD : 32'hC);
        chk("t3_fdone", 32'(bus1.frame_done), 32'd0);
        drive1(1'b1, 1'b1, 1'b1, 1'b0, 1'b0); step();
        chk("t3_sync_pulse", 32'(bus1.sync_err), 32'd0);
        chk("t3_locked", 32'(bus1.locked), 32'd1);

        // Test 2: no marker, 10 clocks of enabled data -> nothing moves
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive1(1'b1, 1'b0, 1'b0, 1'b1, 1'b1); step();
            chk("t2_fdone", 32'(bus1.frame_done), 32'd0);
        end
        chk("t2_slot", 32'(bus1.slot), 32'd0);
        chk("t2_g1q", 32'(bus1.g1q), 32'd0);
        chk("t2_g2q", 32'(bus1.g2q), 32'd0);
        chk("t2_locked", 32'(bus1.locked), 32'd0);

        // Test 4: enb2_n high in slot 1 only; g1 pattern 0,1,1,0
        do_reset();
        drive1(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); step();
        drive1(1'b1, 1'b0, 1'b1, 1'b1, 1'b1); step();
        drive1(1'b1, 1'b0, 1'b0, 1'b1, 1'b1); step();
        chk("t4_g2q_mid", 32'(bus1.g2q), DBUF ? 32'h0 : 32'h5);
        drive1(1'b1, 1'b0, 1'b0, 1'b0, 1'b1); step();
        chk("t4_fdone", 32'(bus1.frame_done), 32'd1);
        chk("t4_g2q", 32'(bus1.g2q), 32'hD);
        chk("t4_g1q", 32'(bus1.g1q), 32'h6);

        // Test 5: reset mid-frame at slot 2
        drive1(1'b0, 1'b0, 1'b0, 1'b1, 1'b1); step();
        drive1(1'b1, 1'b0, 1'b0, 1'b1, 1'b1); step();
        chk("t5_slot2", 32'(bus1.slot), 32'd2);
        reset = 1'b1;
        drive1(1'b0, 1'b0, 1'b0, 1'b1, 1'b1); step();
        chk("t5_slot", 32'(bus1.slot), 32'd0);
        chk("t5_locked", 32'(bus1.locked), 32'd0);
        chk("t5_g1q", 32'(bus1.g1q), 32'd0);
        chk("t5_g2q", 32'(bus1.g2q), 32'd0);
        chk("t5_flags", 32'({bus1.frame_done, bus1.sync_err}), 32'd0);
        reset = 1'b0;
        drive1(1'b1, 1'b0, 1'b0, 1'b1, 1'b1); step();
        chk("t5_hunt", 32'(bus1.locked), 32'd0);

        // Test 6: WIDTH=4 lanes A,B,C,D
        drive1(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        do_reset();
        nib[0] = 4'hA; nib[1] = 4'hB; nib[2] = 4'hC; nib[3] = 4'hD;
        exp16 = 16'h0;
        for (int k = 0; k < 4; k++) begin
            bus4.frame_n = (k == 0) ? 1'b0 : 1'b1;
            bus4.enb1_n  = 1'b0;
            bus4.g1d     = nib[k];
            bus4.g2d     = 4'hF;
            step();
            exp16[k*4 +: 4] = nib[k];
            if (DBUF && k < 3)
                chk("t6_g1q_fill", 32'(bus4.g1q), 32'h0);
            else
                chk("t6_g1q_fill", 32'(bus4.g1q), 32'(exp16));
        end
        chk("t6_g1q", 32'(bus4.g1q), 32'hDCBA);
        chk("t6_fdone", 32'(bus4.frame_done), 32'd1);
        chk("t6_g2q", 32'(bus4.g2q), 32'h0);
        bus4.frame_n = 1'b1; bus4.enb1_n = 1'b0; bus4.g1d = 4'h5;
        step();
        exp4 = DBUF ? 4'hA : 4'h5;
        chk("t6_hold", 32'(bus4.g1q[3:0]), 32'(exp4));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
